// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port (core/debug) arbiter for a single-port word memory with
//            sub-word read-modify-write stores and extended sub-word loads.
//            Optional round-robin arbitration when DMEM_ARB_RR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [1:0]  c_size,
    input  logic        c_uns,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    output logic        c_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_uns,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_ad,
    output logic [31:0] wrtDat,
    output logic        memWrt,
    input  logic [31:0] redDat
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_RMW_WR = 1'b1;

    logic [0:0]  r_state;
    logic        r_owner;
    logic [31:0] r_cap;

    logic        w_pick_d;
    logic        w_sel_d;
    logic        w_active;
    logic        w_sel_we;
    logic [1:0]  w_sel_size;
    logic        w_sel_uns;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_illegal;
    logic        w_sub_st;
    logic        w_gnt;
    logic [31:0] w_merge;
    logic [31:0] w_ld;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

`ifdef DMEM_ARB_RR_EN
    logic r_prio_d;

    // Pointer names the requester that wins a tie; flips to the other side on every grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio_d <= 1'b0;
        end else if (c_gnt) begin
            r_prio_d <= 1'b1;
        end else if (d_gnt) begin
            r_prio_d <= 1'b0;
        end
    end

    assign w_pick_d = d_req && (!c_req || r_prio_d);
`else
    assign w_pick_d = d_req && !c_req;
`endif

    // The owner is locked while the read-modify-write completes.
    assign w_sel_d     = (r_state == S_RMW_WR) ? r_owner : w_pick_d;
    assign w_active    = !rst && ((r_state == S_RMW_WR) || c_req || d_req);
    assign w_sel_we    = w_sel_d ? d_we    : c_we;
    assign w_sel_size  = w_sel_d ? d_size  : c_size;
    assign w_sel_uns   = w_sel_d ? d_uns   : c_uns;
    assign w_sel_addr  = w_sel_d ? d_addr  : c_addr;
    assign w_sel_wdata = w_sel_d ? d_wdata : c_wdata;

    assign w_illegal = (w_sel_size == 2'd3) ||
                       ((w_sel_size == 2'd1) && w_sel_addr[0]) ||
                       ((w_sel_size == 2'd2) && (w_sel_addr[1:0] != 2'b00));
    assign w_sub_st  = w_sel_we && !w_illegal && (w_sel_size != 2'd2);

    always_comb begin
        w_merge = r_cap;
        if (w_sel_size == 2'd0) begin
            w_merge[{w_sel_addr[1:0], 3'b000} +: 8] = w_sel_wdata[7:0];
        end else begin
            w_merge[{w_sel_addr[1], 4'b0000} +: 16] = w_sel_wdata[15:0];
        end
    end

    assign w_byte = redDat[{w_sel_addr[1:0], 3'b000} +: 8];
    assign w_half = redDat[{w_sel_addr[1], 4'b0000} +: 16];

    always_comb begin
        case (w_sel_size)
            2'd0:    w_ld = w_sel_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'd1:    w_ld = w_sel_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_ld = redDat;
        endcase
    end

    always_comb begin
        w_gnt  = 1'b0;
        memWrt = 1'b0;
        wrtDat = 32'd0;
        mem_ad = 32'd0;
        if (w_active) begin
            mem_ad = {w_sel_addr[31:2], 2'b00};
            if (r_state == S_RMW_WR) begin
                w_gnt  = 1'b1;
                memWrt = 1'b1;
                wrtDat = w_merge;
            end else begin
                w_gnt = !w_sub_st;
                if (w_sel_we && !w_illegal && !w_sub_st) begin
                    memWrt = 1'b1;
                    wrtDat = w_sel_wdata;
                end
            end
        end
    end

    assign c_gnt = w_gnt && !w_sel_d;
    assign d_gnt = w_gnt && w_sel_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_owner  <= 1'b0;
            r_cap    <= 32'd0;
            c_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            c_err    <= 1'b0;
            d_err    <= 1'b0;
            c_rdata  <= 32'd0;
            d_rdata  <= 32'd0;
        end else begin
            c_rvalid <= c_gnt;
            d_rvalid <= d_gnt;
            c_err    <= c_gnt && w_illegal;
            d_err    <= d_gnt && w_illegal;
            c_rdata  <= (c_gnt && !w_sel_we && !w_illegal) ? w_ld : 32'd0;
            d_rdata  <= (d_gnt && !w_sel_we && !w_illegal) ? w_ld : 32'd0;
            case (r_state)
                S_IDLE: begin
                    if (w_active && w_sub_st) begin
                        r_state <= S_RMW_WR;
                        r_owner <= w_sel_d;
                        r_cap   <= redDat;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Self-checking bench for dmem_arbiter with a behavioural memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, c_uns, d_req, d_we, d_uns;
    logic [1:0]  c_size, d_size;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
    logic [31:0] c_rdata, d_rdata;
    logic [31:0] mem_ad, wrtDat, redDat;
    logic        memWrt;

    logic [31:0] mem [0:63];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        port;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_rmw;
        logic [31:0] exp_wr;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    vec_t  vecs[$];
    resp_t sbq[$];

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_uns(c_uns),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_gnt(c_gnt), .c_rvalid(c_rvalid),
        .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_uns(d_uns),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .mem_ad(mem_ad), .wrtDat(wrtDat), .memWrt(memWrt), .redDat(redDat)
    );

    always #5 clk = ~clk;

    assign redDat = mem[mem_ad[7:2]];
    always @(posedge clk) if (memWrt) mem[mem_ad[7:2]] <= wrtDat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (!port) begin
            c_req = req; c_we = we; c_size = size; c_uns = uns; c_addr = addr; c_wdata = wdata;
        end else begin
            d_req = req; d_we = we; d_size = size; d_uns = uns; d_addr = addr; d_wdata = wdata;
        end
    endtask

    function automatic vec_t mk(input logic port, input logic we, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input logic exp_rmw, input logic [31:0] exp_wr);
        vec_t v;
        v.port = port; v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_rmw = exp_rmw; v.exp_wr = exp_wr;
        return v;
    endfunction

    task automatic do_access(input vec_t v);
        int    n;
        logic  got;
        logic  gnt;
        resp_t r;
        @(posedge clk); #1;
        drive(v.port, 1'b1, v.we, v.size, v.uns, v.addr, v.wdata);
        r.rdata = v.exp_rdata;
        r.err   = v.exp_err;
        sbq.push_back(r);
        n = 0;
        got = 1'b0;
        while (!got && n < 8) begin
            @(negedge clk);
            gnt = v.port ? d_gnt : c_gnt;
            if (gnt) begin
                got = 1'b1;
                chk("gnt_latency", n, v.exp_rmw ? 32'd1 : 32'd0);
                chk("memWrt_at_gnt", {31'd0, memWrt}, {31'd0, v.we && !v.exp_err});
                if (v.we && !v.exp_err) begin
                    chk("mem_ad", mem_ad, {v.addr[31:2], 2'b00});
                    chk("wrtDat", wrtDat, v.exp_wr);
                end
            end else begin
                chk("memWrt_before_gnt", {31'd0, memWrt}, 32'd0);
                @(posedge clk); #1;
                n++;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL gnt_timeout: no grant after %0d cycles, expected one", n);
            drive(v.port, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
            sbq.delete();
            return;
        end
        @(posedge clk); #1;
        drive(v.port, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("rvalid", {31'd0, v.port ? d_rvalid : c_rvalid}, 32'd1);
        r = sbq.pop_front();
        chk("rdata", v.port ? d_rdata : c_rdata, r.rdata);
        chk("err", {31'd0, v.port ? d_err : c_err}, {31'd0, r.err});
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {c_gnt, d_gnt, c_rvalid, d_rvalid, c_err, d_err, memWrt}, 32'd0);
        chk(name, c_rdata | d_rdata | mem_ad | wrtDat, 32'd0);
    endtask

    initial begin
        logic exp_d;
        logic prev_d;

        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);

        //        port  we    sz    uns   addr    wdata         rdata         err   rmw   wr
        vecs.push_back(mk(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 0, 2'd2, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 2'd2, 0, 32'h10, 32'h11223344, 32'h0,        0, 0, 32'h11223344));
        vecs.push_back(mk(0, 1, 2'd0, 0, 32'h13, 32'h0000005A, 32'h0,        0, 1, 32'h5A223344));
        vecs.push_back(mk(0, 0, 2'd2, 0, 32'h10, 32'h0,        32'h5A223344, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 2'd0, 0, 32'h13, 32'h0,        32'h0000005A, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 2'd0, 0, 32'h12, 32'h0,        32'h00000022, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 2'd2, 0, 32'h20, 32'h11FF3344, 32'h0,        0, 0, 32'h11FF3344));
        vecs.push_back(mk(0, 0, 2'd0, 0, 32'h22, 32'h0,        32'hFFFFFFFF, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 2'd0, 1, 32'h22, 32'h0,        32'h000000FF, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 2'd1, 0, 32'h22, 32'h0,        32'h000011FF, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 2'd1, 1, 32'h20, 32'h0,        32'h00003344, 0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 2'd1, 0, 32'h22, 32'h00008001, 32'h0,        0, 1, 32'h80013344));
        vecs.push_back(mk(1, 0, 2'd1, 0, 32'h22, 32'h0,        32'hFFFF8001, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 2'd1, 1, 32'h22, 32'h0,        32'h00008001, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 2'd1, 0, 32'h11, 32'h0,        32'h0,        1, 0, 32'h0));
        vecs.push_back(mk(1, 1, 2'd2, 0, 32'h06, 32'hCAFEF00D, 32'h0,        1, 0, 32'h0));
        vecs.push_back(mk(0, 0, 2'd3, 0, 32'h10, 32'h0,        32'h0,        1, 0, 32'h0));
        vecs.push_back(mk(1, 0, 2'd0, 0, 32'h11, 32'h0,        32'h00000033, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 2'd2, 0, 32'h04, 32'h0,        32'h00000000, 0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 2'd0, 0, 32'h23, 32'h0000007E, 32'h0,        0, 1, 32'h7E013344));
        vecs.push_back(mk(0, 0, 2'd2, 0, 32'h20, 32'h0,        32'h7E013344, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 2'd0, 1, 32'h10, 32'h0,        32'h00000044, 0, 0, 32'h0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset_outputs");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("idle_outputs");

        foreach (vecs[i]) do_access(vecs[i]);

        // Both ports load continuously starting from a fresh reset.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        prev_d = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
`ifdef DMEM_ARB_RR_EN
            exp_d = k[0];
`else
            exp_d = 1'b0;
`endif
            chk("arb_c_gnt", {31'd0, c_gnt}, {31'd0, !exp_d});
            chk("arb_d_gnt", {31'd0, d_gnt}, {31'd0, exp_d});
            if (k > 0) begin
                chk("arb_rvalid", {31'd0, prev_d ? d_rvalid : c_rvalid}, 32'd1);
                chk("arb_rdata", prev_d ? d_rdata : c_rdata, prev_d ? 32'h7E013344 : 32'h5A223344);
            end
            prev_d = exp_d;
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("arb_last_rvalid", {31'd0, prev_d ? d_rvalid : c_rvalid}, 32'd1);
        chk("arb_last_rdata", prev_d ? d_rdata : c_rdata, prev_d ? 32'h7E013344 : 32'h5A223344);

        // Debug half store owns both cycles; core load waits until after d_gnt.
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000BEEF);
        @(negedge clk);
        chk("rmw_rd_gnts", {30'd0, c_gnt, d_gnt}, 32'd0);
        chk("rmw_rd_memWrt", {31'd0, memWrt}, 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        chk("rmw_wr_gnts", {30'd0, c_gnt, d_gnt}, 32'd1);
        chk("rmw_wr_memWrt", {31'd0, memWrt}, 32'd1);
        chk("rmw_wr_wrtDat", wrtDat, 32'hBEEF3344);
        chk("rmw_wr_mem_ad", mem_ad, 32'h20);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("core_after_rmw_gnt", {30'd0, c_gnt, d_gnt}, 32'd2);
        chk("rmw_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("rmw_d_rdata", d_rdata, 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("core_after_rmw_rvalid", {31'd0, c_rvalid}, 32'd1);
        chk("core_after_rmw_rdata", c_rdata, 32'h5A223344);

        // Reset landing in RMW_WR aborts the write and suppresses the response.
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 32'h10, 32'h00000099);
        @(negedge clk);
        chk("abort_rd_memWrt", {31'd0, memWrt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_memWrt", {31'd0, memWrt}, 32'd0);
        chk("abort_d_gnt", {31'd0, d_gnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk_all_zero("after_abort");
        do_access(mk(0, 0, 2'd2, 0, 32'h10, 32'h0, 32'h5A223344, 0, 0, 32'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
